// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit MCU control unit: opcodes, FSM states,
// status flag positions and the ALU mode codes agreed with the ALU.
package mcu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_JC   = 4'h3;
    localparam logic [3:0] OP_JS   = 4'h4;
    localparam logic [3:0] OP_JO   = 4'h5;
    localparam logic [3:0] OP_LDA  = 4'h6;
    localparam logic [3:0] OP_STA  = 4'h7;
    localparam logic [3:0] OP_ALUA = 4'h8;
    localparam logic [3:0] OP_ALUM = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_S = 1;
    localparam int FLG_O = 0;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_NOT = 4'h5;
    localparam logic [3:0] ALU_SHL = 4'h6;
    localparam logic [3:0] ALU_SHR = 4'h7;

endpackage

// File: rtl/mcu_branch_eval.sv
// Branch resolution: decides whether a jump-class opcode redirects the PC,
// using the status register as latched before the current instruction.
module mcu_branch_eval
    import mcu_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [3:0] sr_i,
    output logic       take_branch_o
);

    always_comb begin
        take_branch_o = 1'b0;
        case (opcode_i)
            OP_JMP:  take_branch_o = 1'b1;
            OP_JZ:   take_branch_o = sr_i[FLG_Z];
            OP_JC:   take_branch_o = sr_i[FLG_C];
            OP_JS:   take_branch_o = sr_i[FLG_S];
            OP_JO:   take_branch_o = sr_i[FLG_O];
            default: take_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcu_ctrl.sv
// Fetch/decode/execute control unit for the 8-bit MCU (ALU requester side).
// Build option MCU_CTRL_TRAP_EN: illegal opcodes set a sticky Trap and halt.
//
// state   | meaning
// IDLE    | waiting for Start
// FETCH   | program read of PC
// DECODE  | IR <= PMemData, PC <= PC+1
// EXECUTE | perform IR action
// HALT    | stopped until reset
module mcu_ctrl
    import mcu_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int DADDR_W  = 4,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    output logic [PC_W-1:0]    PMemAddr,
    output logic               PMemRd,
    input  logic [11:0]        PMemData,
    output logic [DADDR_W-1:0] DMemAddr,
    input  logic [7:0]         DMemRdData,
    output logic [7:0]         DMemWrData,
    output logic               DMemWE,
    output logic [7:0]         AluOp1,
    output logic [7:0]         AluOp2,
    output logic [3:0]         AluMode,
    output logic               AluEn,
    input  logic [7:0]         AluOut,
    input  logic [3:0]         AluFlags,
    output logic [3:0]         Status,
    output logic               Halted,
    output logic               Trap
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [11:0]     ir_q, ir_d;
    logic [7:0]      acc_q, acc_d;
    logic [3:0]      sr_q, sr_d;
    logic            take_branch;
    logic [3:0]      opcode;

    assign opcode = ir_q[11:8];

    mcu_branch_eval u_branch_eval (
        .opcode_i      (opcode),
        .sr_i          (sr_q),
        .take_branch_o (take_branch)
    );

`ifdef MCU_CTRL_TRAP_EN
    logic trap_q, trap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_q <= 1'b0;
        else        trap_q <= trap_d;
    end

    assign Trap = trap_q;
`else
    assign Trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_W'(RESET_PC);
            ir_q    <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
        end
    end

    assign PMemAddr = pc_q;
    assign DMemAddr = ir_q[DADDR_W-1:0];
    assign AluOp1   = acc_q;
    assign AluOp2   = DMemRdData;
    assign Status   = sr_q;
    assign Halted   = (state_q == ST_HALT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        sr_d       = sr_q;
`ifdef MCU_CTRL_TRAP_EN
        trap_d     = trap_q;
`endif
        PMemRd     = 1'b0;
        DMemWE     = 1'b0;
        DMemWrData = acc_q;
        AluEn      = 1'b0;
        AluMode    = ALU_ADD;

        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                PMemRd  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = PMemData;
                pc_d    = pc_q + 1'b1;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_NOP: ;
                    OP_JMP, OP_JZ, OP_JC, OP_JS, OP_JO: begin
                        if (take_branch) pc_d = PC_W'(ir_q[7:0]);
                    end
                    OP_LDA: acc_d = DMemRdData;
                    OP_STA: begin
                        DMemWrData = acc_q;
                        DMemWE     = 1'b1;
                    end
                    OP_ALUA: begin
                        AluEn   = 1'b1;
                        AluMode = ir_q[7:4];
                        acc_d   = AluOut;
                        sr_d    = AluFlags;
                    end
                    OP_ALUM: begin
                        AluEn      = 1'b1;
                        AluMode    = ir_q[7:4];
                        DMemWrData = AluOut;
                        DMemWE     = 1'b1;
                        sr_d       = AluFlags;
                    end
                    OP_LDI:  acc_d   = ir_q[7:0];
                    OP_HALT: state_d = ST_HALT;
`ifdef MCU_CTRL_TRAP_EN
                    default: begin
                        trap_d  = 1'b1;
                        state_d = ST_HALT;
                    end
`else
                    default: ;
`endif
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mcu_ctrl.sv
// Directed self-checking bench for mcu_ctrl with program/data memory and a
// stand-in ALU; data-memory writes are checked through an expected-write queue.
module tb_mcu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  PMemAddr;
    logic        PMemRd;
    logic [11:0] PMemData;
    logic [3:0]  DMemAddr;
    logic [7:0]  DMemRdData;
    logic [7:0]  DMemWrData;
    logic        DMemWE;
    logic [7:0]  AluOp1, AluOp2;
    logic [3:0]  AluMode;
    logic        AluEn;
    logic [7:0]  AluOut;
    logic [3:0]  AluFlags;
    logic [3:0]  Status;
    logic        Halted, Trap;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] pmem [0:255];
    logic [7:0]  dmem [0:15];
    logic [11:0] exp_wr [$];
    logic [11:0] obs_wr [$];

    mcu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Start(Start),
        .PMemAddr(PMemAddr), .PMemRd(PMemRd), .PMemData(PMemData),
        .DMemAddr(DMemAddr), .DMemRdData(DMemRdData), .DMemWrData(DMemWrData),
        .DMemWE(DMemWE), .AluOp1(AluOp1), .AluOp2(AluOp2), .AluMode(AluMode),
        .AluEn(AluEn), .AluOut(AluOut), .AluFlags(AluFlags), .Status(Status),
        .Halted(Halted), .Trap(Trap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (PMemRd) PMemData <= pmem[PMemAddr];
    always @(posedge clk) if (DMemWE) dmem[DMemAddr] <= DMemWrData;
    assign DMemRdData = dmem[DMemAddr];

    always @(negedge clk) if (rst_n && DMemWE) obs_wr.push_back({DMemAddr, DMemWrData});

    // Stand-in ALU: flags {Z,C,S,O}
    always_comb begin
        logic [8:0] t;
        t = 9'd0;
        AluOut   = 8'h00;
        AluFlags = 4'h0;
        case (AluMode)
            4'h0: t = {1'b0, AluOp1} + {1'b0, AluOp2};
            4'h1: t = {1'b0, AluOp1} - {1'b0, AluOp2};
            4'h2: t = {1'b0, AluOp1 & AluOp2};
            4'h3: t = {1'b0, AluOp1 | AluOp2};
            default: t = {1'b0, AluOp1 ^ AluOp2};
        endcase
        AluOut      = t[7:0];
        AluFlags[3] = (t[7:0] == 8'h00);
        AluFlags[2] = t[8];
        AluFlags[1] = t[7];
        AluFlags[0] = (AluMode == 4'h0) && (AluOp1[7] == AluOp2[7]) && (t[7] != AluOp1[7]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_pmem();
        for (int i = 0; i < 256; i++) pmem[i] = 12'h000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic start_prog();
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic drain_wr(input string tag);
        chk({tag, "_wr_count"}, obs_wr.size(), exp_wr.size());
        while (exp_wr.size() > 0 && obs_wr.size() > 0)
            chk({tag, "_wr"}, obs_wr.pop_front(), exp_wr.pop_front());
        exp_wr.delete();
        obs_wr.delete();
    endtask

    initial begin
        int cnt;
        clear_pmem();

        // Reset state
        #1;
        chk("rst_pmemrd", PMemRd, 0);
        chk("rst_dmemwe", DMemWE, 0);
        chk("rst_aluen", AluEn, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_trap", Trap, 0);
        chk("rst_status", Status, 0);
        chk("rst_acc", AluOp1, 0);

        // Program A: LDI 5; STA 3; LDI 7; ADD addr3 -> Acc 0x0C
        pmem[0] = 12'hC05; pmem[1] = 12'h703; pmem[2] = 12'hC07;
        pmem[3] = 12'h803; pmem[4] = 12'hD00;
        exp_wr.push_back({4'h3, 8'h05});
        do_reset();
        tick(2);
        chk("idle_no_fetch", PMemRd, 0);
        start_prog();
        chk("a_fetch_rd", PMemRd, 1);
        chk("a_fetch_addr", PMemAddr, 8'h00);
        tick(1);
        chk("a_decode_rd", PMemRd, 0);
        tick(1);
        chk("a_ir_loaded", DMemAddr, 4'h5);
        tick(1);
        chk("a_pc_inc", PMemAddr, 8'h01);
        chk("a_ldi_acc", AluOp1, 8'h05);
        tick(8);
        chk("a_alu_en", AluEn, 1);
        chk("a_alu_mode", AluMode, 4'h0);
        chk("a_alu_op2", AluOp2, 8'h05);
        tick(1);
        chk("a_fetch4_addr", PMemAddr, 8'h04);
        chk("a_fetch4_rd", PMemRd, 1);
        chk("a_acc_sum", AluOp1, 8'h0C);
        chk("a_status", Status, 4'b0000);
        tick(3);
        chk("a_halted", Halted, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            Start = (i % 5 == 0);
            tick(1);
            if (PMemRd) cnt++;
        end
        Start = 1'b0;
        chk("halt_no_fetch", cnt, 0);
        chk("halt_stays", Halted, 1);
        drain_wr("a");

        // Program B: ALU->Mem 0xFF + 0x01 -> 0x00, Z=1 C=1
        clear_pmem();
        pmem[0] = 12'hC01; pmem[1] = 12'h702; pmem[2] = 12'hCFF;
        pmem[3] = 12'h902; pmem[4] = 12'hD00;
        exp_wr.push_back({4'h2, 8'h01});
        exp_wr.push_back({4'h2, 8'h00});
        do_reset();
        chk("b_status_rst", Status, 0);
        start_prog();
        tick(11);
        chk("b_we", DMemWE, 1);
        chk("b_wrdata", DMemWrData, 8'h00);
        chk("b_alu_en", AluEn, 1);
        tick(1);
        chk("b_status", Status, 4'b1100);
        chk("b_acc_kept", AluOp1, 8'hFF);
        drain_wr("b");

        // Program C1: Z=1, JZ 0x40 taken
        clear_pmem();
        pmem[0] = 12'hC00; pmem[1] = 12'h700; pmem[2] = 12'h800;
        pmem[3] = 12'h240; pmem[8'h40] = 12'hD00;
        exp_wr.push_back({4'h0, 8'h00});
        do_reset();
        start_prog();
        tick(12);
        chk("c1_z_set", Status[3], 1);
        chk("c1_jz_taken", PMemAddr, 8'h40);
        drain_wr("c1");

        // Program C2: Z=0, JZ at 0x10 not taken
        clear_pmem();
        pmem[0] = 12'hC01; pmem[1] = 12'h700; pmem[2] = 12'h800;
        pmem[3] = 12'h110; pmem[8'h10] = 12'h240; pmem[8'h11] = 12'hD00;
        exp_wr.push_back({4'h0, 8'h01});
        do_reset();
        start_prog();
        tick(12);
        chk("c2_jmp", PMemAddr, 8'h10);
        chk("c2_status", Status, 4'b0000);
        tick(3);
        chk("c2_jz_not_taken", PMemAddr, 8'h11);
        drain_wr("c2");

        // Program D: JMP 0xFF; JC not taken at 0xFF wraps to 0x00
        clear_pmem();
        pmem[0] = 12'h1FF; pmem[8'hFF] = 12'h355;
        do_reset();
        start_prog();
        tick(3);
        chk("d_jmp_ff", PMemAddr, 8'hFF);
        tick(3);
        chk("d_wrap", PMemAddr, 8'h00);
        chk("d_wrap_rd", PMemRd, 1);

        // Program E: illegal opcode 0xE00
        clear_pmem();
        pmem[0] = 12'hE00; pmem[1] = 12'hD00;
        do_reset();
        start_prog();
        tick(3);
`ifdef MCU_CTRL_TRAP_EN
        chk("e_trap", Trap, 1);
        chk("e_halted", Halted, 1);
        chk("e_no_fetch", PMemRd, 0);
`else
        chk("e_trap", Trap, 0);
        chk("e_nop_next", PMemAddr, 8'h01);
        chk("e_nop_rd", PMemRd, 1);
`endif

        // Program F: reset during EXECUTE of STA aborts the write
        clear_pmem();
        pmem[0] = 12'hC0A; pmem[1] = 12'h705;
        do_reset();
        chk("f_trap_cleared", Trap, 0);
        start_prog();
        tick(5);
        chk("f_sta_we", DMemWE, 1);
        chk("f_sta_data", DMemWrData, 8'h0A);
        rst_n = 1'b0;
        #1;
        chk("f_rst_we", DMemWE, 0);
        chk("f_rst_rd", PMemRd, 0);
        chk("f_rst_acc", AluOp1, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("f_idle", PMemRd, 0);
        chk("f_idle_halt", Halted, 0);
        drain_wr("f");
        chk("f_mem_untouched", dmem[5] === 8'h0A, 0);
        start_prog();
        chk("f_restart_addr", PMemAddr, 8'h00);
        chk("f_restart_rd", PMemRd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
